sram_axi_bridge: RTL and testbench
==================================

Name: sram_axi_bridge

Overview:
Responder for the core's inst/data SRAM-like request interfaces. It accepts req/addr/size/wstrb/wdata, returns addr_ok/data_ok/rdata, and converts each transaction into single-beat AXI3 master transactions toward the system bus. It sits between cpu_core and the SoC AXI crossbar and is instantiated in the top-level wrapper beside the core.

Parameters:
INST_ID, 4'd0, AXI ID used for instruction reads.
DATA_ID, 4'd1, AXI ID used for data reads and all writes.

Ports:
clk  in  1  clock; all logic on posedge
resetn  in  1  synchronous active-low reset
inst_sram_req  in  1  inst read request (inst port is read-only)
inst_sram_size  in  2  0=byte, 1=half, 2=word
inst_sram_addr  in  32  byte address
inst_sram_addr_ok  out  1  inst request accepted this cycle
inst_sram_data_ok  out  1  inst read data valid (1-cycle pulse)
inst_sram_rdata  out  32  inst read data
data_sram_req  in  1  data request
data_sram_wr  in  1  1=write, 0=read
data_sram_size  in  2  as inst
data_sram_addr  in  32  byte address
data_sram_wstrb  in  4  byte enables (writes)
data_sram_wdata  in  32  write data
data_sram_addr_ok  out  1  data request accepted this cycle
data_sram_data_ok  out  1  read data valid / write complete (pulse)
data_sram_rdata  out  32  data read data
arid/araddr/arsize/arvalid  out  4/32/3/1  AXI read address
arready  in  1
rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI read data
rready  out  1
awid/awaddr/awsize/awvalid  out  4/32/3/1  AXI write address
awready  in  1
wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI write data
wready  in  1
bid/bresp/bvalid  in  4/2/1  AXI write response
bready  out  1
arlen/awlen, arburst/awburst, arlock/awlock, arcache/awcache, arprot/awprot  out  8/2/2/4/3 each  constants 0, 2'b01, 0, 0, 0

Behaviour:
- Reset (resetn=0 at posedge): both FSMs idle; all valid/ready/addr_ok/data_ok outputs 0; rdata outputs 0. The AXI slave shares this reset. Outstanding transactions are abandoned.
- One outstanding read, one outstanding write. Data port has at most one outstanding transaction of either kind. It accepts a new request only when its previous data_ok has been delivered.
- Read FSM R_IDLE -> R_AR -> R_R -> R_IDLE.
  - R_IDLE: if data read is eligible, accept it; else if inst read is eligible, accept it. Data has priority.
  - Acceptance is combinational: addr_ok=1 in the same cycle req=1. Latch addr, size, id. Go to R_AR.
  - R_AR: arvalid=1, fields held stable, until arready. Then go to R_R.
  - R_R: rready=1. On rvalid, latch rdata into the port selected by rid. Pulse that port's data_ok on the next cycle. rdata holds until the next data_ok for that port. Return to R_IDLE.
- Write FSM W_IDLE -> W_REQ -> W_B -> W_IDLE.
  - W_IDLE: accept a data write (addr_ok=1 same cycle); latch addr/size/wstrb/wdata.
  - W_REQ: awvalid and wvalid both start at 1. Each drops independently after its own handshake (aw_done/w_done flags). Both may complete in the same cycle. Once both are done, go to W_B.
  - W_B: bready=1. On bvalid, pulse data_sram_data_ok next cycle; go to W_IDLE.
- RAW hazard: inst read is ineligible while a write is outstanding with addr[31:2] equal to the inst addr[31:2].
- Simultaneous data read and data write cannot both be present (single data req). An inst read may be accepted in the same cycle as a data write.
- Field rules:
  - arsize/awsize = {1'b0,size}.
  - wstrb passes through unmodified; wlast=1 always.
  - arid = INST_ID or DATA_ID; awid = wid = DATA_ID.
  - rresp/bresp are ignored; rlast is assumed 1.
- addr_ok is never asserted while the corresponding req=0.
- Latency (zero-wait slave): req/addr_ok cycle T; arvalid&arready T+1; rvalid T+2; data_ok T+3.

Decomposition:
- Shared package (myCPU.h): AXI constant defines (burst INCR, len 0), INST_ID/DATA_ID defaults, read/write FSM state encodings.
- One natural sub-module: axi_wr_channel (W_REQ aw/w split-handshake plus B wait). The read path and arbitration stay in the top module.

Test Plan:
- Inst read of word 0x1c000000, arready/rvalid immediate, rdata=0x02800c21 -> addr_ok at T, arvalid/arid=0 at T+1, inst_sram_data_ok=1 with rdata=0x02800c21 at T+3.
- Inst and data reads requested in the same cycle (addr 0x100, 0x200) -> data_sram_addr_ok=1, inst_sram_addr_ok=0. Data araddr=0x200 goes first; inst accepted after data R handshake.
- Data write addr 0x80, wdata 0xdeadbeef, wstrb 4'b0011, size=1. awready 2 cycles before wready -> awvalid drops first, wvalid holds. awsize=1, wstrb=4'b0011. data_ok one cycle after bvalid.
- Write to 0x40 pending (bvalid delayed 5 cycles), inst read 0x40 -> inst_sram_addr_ok=0 until the B handshake. Inst read 0x44 under the same condition is accepted immediately.
- Back-to-back data reads with rvalid delayed 3 cycles -> second addr_ok only after first data_ok. rdata values in order.
- resetn=0 while in R_R and W_REQ -> next cycle arvalid=awvalid=wvalid=rready=bready=0, data_ok=0. New inst read after release completes normally.

Source files
------------

// File: rtl/sram_axi_bridge_pkg.sv
// Shared constants, FSM encodings and payload types for the SRAM-to-AXI bridge.
package sram_axi_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [ID_W-1:0] DEF_INST_ID = 4'd0;
  localparam logic [ID_W-1:0] DEF_DATA_ID = 4'd1;

  // Single-beat, normal, non-cacheable, unprivileged accesses only
  localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE  = 4'd0;
  localparam logic [2:0] AXI_PROT_NONE   = 3'd0;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } wr_req_t;

  function automatic logic same_word(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:2] == b[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/sram_axi_bridge_axi_wr_channel.sv
// Single-beat AXI write: independent AW/W handshakes, then wait for B.
module axi_wr_channel
  import sram_axi_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  wr_req_t           req,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready,
  output logic              busy_c,
  output logic              done_c
);

  w_state_e state_q, state_d;
  wr_req_t  req_q, req_d;
  logic     awvalid_q, awvalid_d;
  logic     wvalid_q, wvalid_d;
  logic     bready_q, bready_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= W_IDLE;
      req_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    done_c    = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (start) begin
          req_d     = req;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = W_REQ;
        end
      end
      W_REQ: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready) wvalid_d = 1'b0;
        // A cleared valid is the "done" flag for that channel
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = W_B;
        end
      end
      W_B: begin
        if (bvalid) begin
          bready_d = 1'b0;
          done_c   = 1'b1;
          state_d  = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  assign awaddr  = req_q.addr;
  assign awsize  = {1'b0, req_q.size};
  assign awvalid = awvalid_q;
  assign wdata   = req_q.wdata;
  assign wstrb   = req_q.wstrb;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;
  assign busy_c  = (state_q != W_IDLE);

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst/data SRAM-like ports onto single-beat AXI3 transactions.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [ID_W-1:0] INST_ID = DEF_INST_ID,
  parameter logic [ID_W-1:0] DATA_ID = DEF_DATA_ID
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_sram_req,
  input  logic [1:0]        inst_sram_size,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  output logic              inst_sram_addr_ok,
  output logic              inst_sram_data_ok,
  output logic [DATA_W-1:0] inst_sram_rdata,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [STRB_W-1:0] data_sram_wstrb,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  output logic [ID_W-1:0]   wid,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  r_state_e          r_state_q, r_state_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic [1:0]        ar_size_q, ar_size_d;
  logic [ID_W-1:0]   ar_id_q, ar_id_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              inst_ok_q, inst_ok_d;
  logic              data_ok_q, data_ok_d;
  logic              data_busy_q, data_busy_d;
  logic              data_rd_acc_c, data_wr_acc_c, inst_rd_acc_c, raw_hazard_c;
  logic              wr_busy_c, wr_done_c;
  wr_req_t           wr_req_c;
  logic              unused_c;

  // Acceptance: data reads beat inst reads; inst reads wait out same-word writes
  always_comb begin
    data_rd_acc_c = resetn && data_sram_req && !data_sram_wr && !data_busy_q &&
                    (r_state_q == R_IDLE);
    data_wr_acc_c = resetn && data_sram_req && data_sram_wr && !data_busy_q && !wr_busy_c;
    raw_hazard_c  = (wr_busy_c && same_word(awaddr, inst_sram_addr)) ||
                    (data_wr_acc_c && same_word(data_sram_addr, inst_sram_addr));
    inst_rd_acc_c = resetn && inst_sram_req && (r_state_q == R_IDLE) &&
                    !data_rd_acc_c && !raw_hazard_c;
    wr_req_c      = '{addr: data_sram_addr, size: data_sram_size,
                      wstrb: data_sram_wstrb, wdata: data_sram_wdata};
    unused_c      = ^{rresp, rlast, bid, bresp};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_q    <= R_IDLE;
      ar_addr_q    <= '0;
      ar_size_q    <= '0;
      ar_id_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      data_busy_q  <= 1'b0;
    end else begin
      r_state_q    <= r_state_d;
      ar_addr_q    <= ar_addr_d;
      ar_size_q    <= ar_size_d;
      ar_id_q      <= ar_id_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_ok_q    <= inst_ok_d;
      data_ok_q    <= data_ok_d;
      data_busy_q  <= data_busy_d;
    end
  end

  always_comb begin
    r_state_d    = r_state_q;
    ar_addr_d    = ar_addr_q;
    ar_size_d    = ar_size_q;
    ar_id_d      = ar_id_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_ok_d    = 1'b0;
    data_ok_d    = wr_done_c;
    data_busy_d  = data_busy_q;
    case (r_state_q)
      R_IDLE: begin
        if (data_rd_acc_c) begin
          ar_addr_d = data_sram_addr;
          ar_size_d = data_sram_size;
          ar_id_d   = DATA_ID;
          arvalid_d = 1'b1;
          r_state_d = R_AR;
        end else if (inst_rd_acc_c) begin
          ar_addr_d = inst_sram_addr;
          ar_size_d = inst_sram_size;
          ar_id_d   = INST_ID;
          arvalid_d = 1'b1;
          r_state_d = R_AR;
        end
      end
      R_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          r_state_d = R_R;
        end
      end
      R_R: begin
        if (rvalid) begin
          rready_d  = 1'b0;
          r_state_d = R_IDLE;
          if (rid == INST_ID) begin
            inst_rdata_d = rdata;
            inst_ok_d    = 1'b1;
          end else begin
            data_rdata_d = rdata;
            data_ok_d    = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Data port stays busy through the cycle its data_ok is shown
    if (data_ok_q) data_busy_d = 1'b0;
    if (data_rd_acc_c || data_wr_acc_c) data_busy_d = 1'b1;
  end

  axi_wr_channel u_wr (
    .clk     (clk),
    .resetn  (resetn),
    .start   (data_wr_acc_c),
    .req     (wr_req_c),
    .awaddr  (awaddr),
    .awsize  (awsize),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bvalid  (bvalid),
    .bready  (bready),
    .busy_c  (wr_busy_c),
    .done_c  (wr_done_c)
  );

  assign inst_sram_addr_ok = inst_rd_acc_c;
  assign data_sram_addr_ok = data_rd_acc_c || data_wr_acc_c;
  assign inst_sram_data_ok = inst_ok_q;
  assign data_sram_data_ok = data_ok_q;
  assign inst_sram_rdata   = inst_rdata_q;
  assign data_sram_rdata   = data_rdata_q;

  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arsize  = {1'b0, ar_size_q};
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_NORMAL;
  assign arcache = AXI_CACHE_NONE;
  assign arprot  = AXI_PROT_NONE;

  assign awid    = DATA_ID;
  assign wid     = DATA_ID;
  assign wlast   = 1'b1;
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = AXI_LOCK_NORMAL;
  assign awcache = AXI_CACHE_NONE;
  assign awprot  = AXI_PROT_NONE;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays the AXI slave cycle by cycle.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_addr_ok, inst_sram_data_ok;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_rdata;
  logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0]  data_sram_wstrb;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
    .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    inst_sram_req = 1'b0; inst_sram_size = 2'd0; inst_sram_addr = '0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0;
    data_sram_addr = '0; data_sram_wstrb = '0; data_sram_wdata = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
    step(); step();

    // Reset state
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_inst_data_ok", inst_sram_data_ok, 0);
    chk("rst_data_data_ok", data_sram_data_ok, 0);
    chk("rst_inst_rdata", inst_sram_rdata, 0);
    chk("rst_data_rdata", data_sram_rdata, 0);
    chk("const_arburst", arburst, 1);
    chk("const_awlen", awlen, 0);
    resetn = 1'b1; arready = 1'b1;
    step();

    // Inst read, zero-wait slave
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000000; inst_sram_size = 2'd2; #1;
    chk("t1_addr_ok", inst_sram_addr_ok, 1);
    step(); inst_sram_req = 1'b0; #1;
    chk("t1_arvalid", arvalid, 1);
    chk("t1_arid", arid, 0);
    chk("t1_araddr", araddr, 32'h1c000000);
    chk("t1_arsize", arsize, 2);
    step();
    chk("t1_rready", rready, 1);
    chk("t1_arvalid_low", arvalid, 0);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h02800c21;
    step(); rvalid = 1'b0;
    chk("t1_data_ok", inst_sram_data_ok, 1);
    chk("t1_rdata", inst_sram_rdata, 32'h02800c21);
    chk("t1_d_data_ok", data_sram_data_ok, 0);
    step();
    chk("t1_data_ok_pulse", inst_sram_data_ok, 0);
    chk("t1_rdata_hold", inst_sram_rdata, 32'h02800c21);

    // Simultaneous inst and data reads: data wins
    inst_sram_req = 1'b1; inst_sram_addr = 32'h100; inst_sram_size = 2'd2;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h200; data_sram_size = 2'd2; #1;
    chk("t2_d_addr_ok", data_sram_addr_ok, 1);
    chk("t2_i_addr_ok", inst_sram_addr_ok, 0);
    step(); data_sram_req = 1'b0; #1;
    chk("t2_araddr", araddr, 32'h200);
    chk("t2_arid", arid, 1);
    chk("t2_i_blocked_ar", inst_sram_addr_ok, 0);
    step();
    chk("t2_rready", rready, 1);
    chk("t2_i_blocked_r", inst_sram_addr_ok, 0);
    rvalid = 1'b1; rid = 4'd1; rdata = 32'haaaa5555;
    step(); rvalid = 1'b0; #1;
    chk("t2_d_data_ok", data_sram_data_ok, 1);
    chk("t2_d_rdata", data_sram_rdata, 32'haaaa5555);
    chk("t2_i_addr_ok", inst_sram_addr_ok, 1);
    step(); inst_sram_req = 1'b0; #1;
    chk("t2_araddr_inst", araddr, 32'h100);
    chk("t2_arid_inst", arid, 0);
    chk("t2_d_data_ok_pulse", data_sram_data_ok, 0);
    step(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h11112222;
    step(); rvalid = 1'b0;
    chk("t2_i_data_ok", inst_sram_data_ok, 1);
    chk("t2_i_rdata", inst_sram_rdata, 32'h11112222);
    chk("t2_d_rdata_hold", data_sram_rdata, 32'haaaa5555);
    step();

    // Write with AW accepted two cycles before W
    awready = 1'b0; wready = 1'b0;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h80; data_sram_size = 2'd1;
    data_sram_wstrb = 4'b0011; data_sram_wdata = 32'hdeadbeef; #1;
    chk("t3_addr_ok", data_sram_addr_ok, 1);
    step(); data_sram_req = 1'b0; #1;
    chk("t3_awvalid", awvalid, 1);
    chk("t3_wvalid", wvalid, 1);
    chk("t3_awaddr", awaddr, 32'h80);
    chk("t3_awsize", awsize, 1);
    chk("t3_wstrb", wstrb, 4'b0011);
    chk("t3_wdata", wdata, 32'hdeadbeef);
    chk("t3_wlast", wlast, 1);
    chk("t3_awid", awid, 1);
    chk("t3_wid", wid, 1);
    awready = 1'b1;
    step(); awready = 1'b0;
    chk("t3_awvalid_drop", awvalid, 0);
    chk("t3_wvalid_hold", wvalid, 1);
    chk("t3_bready_early", bready, 0);
    step();
    chk("t3_wvalid_hold2", wvalid, 1);
    wready = 1'b1;
    step(); wready = 1'b0;
    chk("t3_wvalid_drop", wvalid, 0);
    chk("t3_bready", bready, 1);
    chk("t3_no_early_ok", data_sram_data_ok, 0);
    bvalid = 1'b1;
    step(); bvalid = 1'b0;
    chk("t3_data_ok", data_sram_data_ok, 1);
    chk("t3_bready_drop", bready, 0);
    step();
    chk("t3_data_ok_pulse", data_sram_data_ok, 0);

    // RAW: inst read of a word being written stalls until B completes
    awready = 1'b1; wready = 1'b1;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h40; data_sram_size = 2'd2;
    data_sram_wstrb = 4'hf; data_sram_wdata = 32'h12345678;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h40; inst_sram_size = 2'd2; #1;
    chk("t4_d_addr_ok", data_sram_addr_ok, 1);
    chk("t4_i_same_cycle", inst_sram_addr_ok, 0);
    step(); data_sram_req = 1'b0; #1;
    chk("t4_i_wreq", inst_sram_addr_ok, 0);
    step();
    chk("t4_bready", bready, 1);
    chk("t4_i_wb", inst_sram_addr_ok, 0);
    step(); step(); step(); step();
    chk("t4_i_wb_late", inst_sram_addr_ok, 0);
    bvalid = 1'b1; #1;
    chk("t4_i_at_b", inst_sram_addr_ok, 0);
    step(); bvalid = 1'b0; #1;
    chk("t4_d_data_ok", data_sram_data_ok, 1);
    chk("t4_i_released", inst_sram_addr_ok, 1);
    step(); inst_sram_req = 1'b0; #1;
    chk("t4_araddr", araddr, 32'h40);
    step(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h40404040;
    step(); rvalid = 1'b0;
    chk("t4_i_data_ok", inst_sram_data_ok, 1);
    chk("t4_i_rdata", inst_sram_rdata, 32'h40404040);
    step();

    // Different word (0x44) under a pending write to 0x40 goes straight through
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h40;
    data_sram_wdata = 32'h5a5a5a5a; #1;
    chk("t4b_d_addr_ok", data_sram_addr_ok, 1);
    step(); data_sram_req = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h44; #1;
    chk("t4b_i_addr_ok", inst_sram_addr_ok, 1);
    step(); inst_sram_req = 1'b0; #1;
    chk("t4b_araddr", araddr, 32'h44);
    chk("t4b_bready", bready, 1);
    step(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h44444444;
    step(); rvalid = 1'b0;
    chk("t4b_i_data_ok", inst_sram_data_ok, 1);
    chk("t4b_i_rdata", inst_sram_rdata, 32'h44444444);
    chk("t4b_d_no_ok", data_sram_data_ok, 0);
    bvalid = 1'b1;
    step(); bvalid = 1'b0;
    chk("t4b_d_data_ok", data_sram_data_ok, 1);
    step();

    // Back-to-back data reads, R delayed three cycles
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h300; data_sram_size = 2'd2; #1;
    chk("t5_addr_ok1", data_sram_addr_ok, 1);
    step(); data_sram_addr = 32'h304; #1;
    chk("t5_block_ar", data_sram_addr_ok, 0);
    step(); #1;
    chk("t5_rready", rready, 1);
    chk("t5_block_r", data_sram_addr_ok, 0);
    step(); step(); #1;
    chk("t5_block_wait", data_sram_addr_ok, 0);
    step(); rvalid = 1'b1; rid = 4'd1; rdata = 32'h33333333;
    step(); rvalid = 1'b0; #1;
    chk("t5_data_ok1", data_sram_data_ok, 1);
    chk("t5_rdata1", data_sram_rdata, 32'h33333333);
    chk("t5_block_at_ok", data_sram_addr_ok, 0);
    step(); #1;
    chk("t5_addr_ok2", data_sram_addr_ok, 1);
    chk("t5_ok_pulse", data_sram_data_ok, 0);
    step(); data_sram_req = 1'b0; #1;
    chk("t5_araddr2", araddr, 32'h304);
    step(); rvalid = 1'b1; rid = 4'd1; rdata = 32'h34343434;
    step(); rvalid = 1'b0;
    chk("t5_data_ok2", data_sram_data_ok, 1);
    chk("t5_rdata2", data_sram_rdata, 32'h34343434);
    step();

    // Reset mid-flight with reads in R_R and write in W_REQ
    awready = 1'b0; wready = 1'b0;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h500;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h600; data_sram_wdata = 32'h66666666; #1;
    chk("t6_i_addr_ok", inst_sram_addr_ok, 1);
    chk("t6_d_addr_ok", data_sram_addr_ok, 1);
    step(); inst_sram_req = 1'b0; data_sram_req = 1'b0; #1;
    chk("t6_arvalid", arvalid, 1);
    chk("t6_awvalid", awvalid, 1);
    step();
    chk("t6_rready", rready, 1);
    chk("t6_wvalid", wvalid, 1);
    resetn = 1'b0;
    step();
    chk("t6_rst_arvalid", arvalid, 0);
    chk("t6_rst_awvalid", awvalid, 0);
    chk("t6_rst_wvalid", wvalid, 0);
    chk("t6_rst_rready", rready, 0);
    chk("t6_rst_bready", bready, 0);
    chk("t6_rst_i_ok", inst_sram_data_ok, 0);
    chk("t6_rst_d_ok", data_sram_data_ok, 0);
    chk("t6_rst_i_rdata", inst_sram_rdata, 0);
    resetn = 1'b1; awready = 1'b1; wready = 1'b1;
    step();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h700; #1;
    chk("t6_new_addr_ok", inst_sram_addr_ok, 1);
    step(); inst_sram_req = 1'b0; #1;
    chk("t6_new_araddr", araddr, 32'h700);
    step(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h77777777;
    step(); rvalid = 1'b0;
    chk("t6_new_data_ok", inst_sram_data_ok, 1);
    chk("t6_new_rdata", inst_sram_rdata, 32'h77777777);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
